// File: rtl/edeser_rx_if.sv
// edeser_rx_if: lane data, bitslip request and deserialized word bus for edeser_rx_param.
`default_nettype none

interface edeser_rx_if #(
    parameter int LANES = 9,
    parameter int DIV   = 4
);
    localparam int W  = 2 * DIV;
    localparam int SW = $clog2(W);

    logic [LANES-1:0]   rx_in;
    logic               bitslip;
    logic [LANES*W-1:0] data_out;
    logic               data_valid;
    logic [SW-1:0]      slip_pos;

    modport master (
        output rx_in, bitslip,
        input  data_out, data_valid, slip_pos
    );

    modport slave (
        input  rx_in, bitslip,
        output data_out, data_valid, slip_pos
    );
endinterface

`default_nettype wire

// File: rtl/edeser_rx_param.sv
// edeser_rx_param: LANES-wide DDR deserializer, W=2*DIV bits per lane per word, with bitslip.
// Slip logic is compiled in only when EDESER_BITSLIP_EN is defined.
`default_nettype none

module edeser_rx_param #(
    parameter int LANES = 9,
    parameter int DIV   = 4
) (
    input  logic        rxi_lclk,
    input  logic        reset,
    edeser_rx_if.slave  bus
);
    localparam int W  = 2 * DIV;
    localparam int SW = $clog2(W);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [LANES-1:0]        rise_r;
    logic [LANES-1:0]        fall_r;
    logic [LANES-1:0][W:0]   hist;
    logic [LANES-1:0][W:0]   hist_next;
    logic [LANES*W-1:0]      word_next;
    logic [LANES*W-1:0]      data_out_r;
    logic                    data_valid_r;
    logic [CW-1:0]           cnt;
    logic                    cnt_last;
    logic                    half;
    logic                    hold;
    logic                    fire;
    logic [SW-1:0]           slip_pos_r;

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) rise_r <= '0;
        else       rise_r <= bus.rx_in;
    end

    always_ff @(negedge rxi_lclk or posedge reset) begin
        if (reset) fall_r <= '0;
        else       fall_r <= bus.rx_in;
    end

    // Oldest bit lives at the MSB; the word window is taken from the post-shift history.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic unused_hist_top;
        assign unused_hist_top = ^hist[i][W:W-1];
        assign hist_next[i] = {hist[i][W-2:0], rise_r[i], fall_r[i]};
        assign word_next[i*W +: W] = half ? hist_next[i][W:1] : hist_next[i][W-1:0];
    end

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) hist <= '0;
        else       hist <= hist_next;
    end

`ifdef EDESER_BITSLIP_EN
    logic bitslip_r;
    logic slip_evt;

    assign slip_evt = bus.bitslip & ~bitslip_r;
    // Entering the odd half costs one extra cycle so the boundary lands one bit later.
    assign hold     = slip_evt & ~half;

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) begin
            bitslip_r  <= 1'b0;
            half       <= 1'b0;
            slip_pos_r <= '0;
        end else begin
            bitslip_r <= bus.bitslip;
            if (slip_evt) begin
                half       <= ~half;
                slip_pos_r <= (slip_pos_r == SW'(W-1)) ? '0 : slip_pos_r + 1'b1;
            end
        end
    end
`else
    logic unused_bitslip;
    assign unused_bitslip = bus.bitslip;
    assign hold           = 1'b0;
    assign half           = 1'b0;
    assign slip_pos_r     = '0;
`endif

    assign cnt_last = (cnt == CW'(DIV-1));
    assign fire     = cnt_last & ~hold;

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge rxi_lclk or posedge reset) begin
        if (reset) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= fire;
            if (fire) data_out_r <= word_next;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.slip_pos   = slip_pos_r;
endmodule

`default_nettype wire

// File: tb/tb_edeser_rx_param.sv
// tb_edeser_rx_param: scoreboard bench for edeser_rx_param (LANES=9, DIV=4).
`timescale 1ns/1ps
`default_nettype none

module tb_edeser_rx_param;
    localparam int LANES = 9;
    localparam int DIV   = 4;
    localparam int W     = 2 * DIV;
    localparam int DW    = LANES * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edeser_rx_if #(.LANES(LANES), .DIV(DIV)) bus ();

    edeser_rx_param #(.LANES(LANES), .DIV(DIV)) dut (
        .rxi_lclk (clk),
        .reset    (rst),
        .bus      (bus)
    );

    logic [7:0]    pat [LANES];
    logic [DW-1:0] q [$];
    int  ecnt, cyc, slips, checks, errors, last_v, nvalid;
    bit  sb_en, sb_arm, rnd, first_chk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_slips();
`ifdef EDESER_BITSLIP_EN
        return slips % W;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] p, input int s);
        logic [15:0] d;
        d = {p, p} << s;
        return d[15:8];
    endfunction

    function automatic logic [DW-1:0] exp_word();
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = rotl(pat[i], eff_slips());
        return v;
    endfunction

    // Lane bits for edge k: the rise bit is stream bit 2k, the fall bit 2k+1 (MSB first).
    function automatic logic [LANES-1:0] lane_bits(input int k, input int fall);
        logic [LANES-1:0] v;
        logic [7:0] p;
        for (int i = 0; i < LANES; i++) begin
            p = pat[i];
            v[i] = rnd ? 1'($urandom) : p[7 - ((2*k + fall) % 8)];
        end
        return v;
    endfunction

    // Driver: counts edges since reset release and queues one expected word per stream word.
    always begin
        @(posedge clk);
        cyc++;
        if (rst) ecnt = 0;
        else     ecnt++;
        if (!rst && (ecnt % 4 == 3) && ecnt >= 7) begin
            if (sb_arm) begin
                q.delete();
                sb_en  = 1'b1;
                sb_arm = 1'b0;
                last_v = -1;
            end
            if (sb_en) q.push_back(exp_word());
        end
        #1 bus.rx_in = lane_bits(ecnt, 1);
        @(negedge clk);
        #1 bus.rx_in = lane_bits(ecnt + 1, 0);
    end

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.data_valid) begin
            nvalid++;
            if (first_chk) begin
                first_chk = 1'b0;
                check("first_valid_edge", DW'(ecnt), DW'(DIV));
                check("first_word_lane8", DW'(bus.data_out[70:64]), DW'(7'h7f));
            end
            if (sb_en) begin
                if (q.size() == 0) check("sb_underflow", DW'(1), DW'(0));
                else               check("data_out", bus.data_out, q.pop_front());
                if (last_v >= 0) check("valid_period", DW'(cyc - last_v), DW'(DIV));
                last_v = cyc;
            end
        end
    end

    task automatic steady(input string tag);
        sb_arm = 1'b1;
        repeat (8) @(posedge clk);
        check({tag, "_armed"}, DW'(sb_en), DW'(1));
        nvalid = 0;
        repeat (40) @(posedge clk);
        check({tag, "_valid_count"}, DW'(nvalid), DW'(10));
        check({tag, "_slip_pos"}, DW'(bus.slip_pos), DW'(eff_slips()));
        sb_en = 1'b0;
    endtask

    // Bitslip held high for three cycles must still count as one request.
    task automatic slip();
        @(negedge clk); #1 bus.bitslip = 1'b1;
        repeat (3) @(negedge clk);
        #1 bus.bitslip = 1'b0;
        repeat (2) @(negedge clk);
        slips++;
    endtask

    task automatic release_reset();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk); #2;
        check({tag, "_data"}, bus.data_out, '0);
        check({tag, "_valid"}, DW'(bus.data_valid), DW'(0));
        check({tag, "_slip"}, DW'(bus.slip_pos), DW'(0));
    endtask

    initial begin
        bus.bitslip = 1'b0;
        bus.rx_in   = '0;
        for (int i = 0; i < LANES; i++) pat[i] = 8'h00;
        rnd = 1'b1;
        repeat (4) reset_checks("rst");

        rnd = 1'b0;
        pat[0] = 8'hA5;
        release_reset();
        steady("aligned");

        slip();
        repeat (10) @(posedge clk);
        steady("slip1");

        @(negedge clk); #1 rst = 1'b1;
        slips = 0;
        reset_checks("rst2");
        release_reset();
        for (int n = 0; n < 8; n++) begin
            slip();
            if (n == 0) check("slip_pos_one", DW'(bus.slip_pos), DW'(eff_slips()));
        end
        repeat (10) @(posedge clk);
        steady("slip8");

        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b1;
        slips  = 0;
        pat[0] = 8'h00;
        pat[8] = 8'hFF;
        reset_checks("rst3");
        first_chk = 1'b1;
        release_reset();
        repeat (10) @(posedge clk);
        check("first_valid_seen", DW'(first_chk), DW'(0));
        first_chk = 1'b0;
        steady("lane8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
